io_dev_sched: RTL

//   Sequences character traffic between the G-15 I/O control state and a host-side byte channel.

---
 rtl/io_dev_sched_pkg.sv | 33 +++
 rtl/io_dev_sched_if.sv | 29 ++
 rtl/io_dev_sched_pace_ctr.sv | 28 ++
 rtl/io_dev_sched.sv | 107 ++++++++++
 4 files changed

// File: rtl/io_dev_sched_pkg.sv
// io_dev_sched_pkg: shared types for the G-15 slow-device I/O scheduler.
//   io_dev_e          device code as carried in the host byte {dev, char}
//   io_sched_state_e  scheduler FSM states
//   pace_of()         word-time pacing for a device, given the three rates
package io_dev_sched_pkg;

  localparam int unsigned DEF_TYPE_PACE_WT  = 345;
  localparam int unsigned DEF_PUNCH_PACE_WT = 203;
  localparam int unsigned DEF_READ_PACE_WT  = 14;
  localparam int unsigned DEF_CNT_W         = 10;

  typedef enum logic [1:0] {
    DEV_TYPE  = 2'd0,
    DEV_PUNCH = 2'd1,
    DEV_READ  = 2'd2,
    DEV_KEYB  = 2'd3
  } io_dev_e;

  typedef enum logic [2:0] {
    IDLE, ARM, PACE, OUT_WAIT, OUT_XFER, IN_WAIT, IN_DELIVER
  } io_sched_state_e;

  // Keyboard shares the typewriter mechanism, so it shares its rate.
  function automatic int unsigned pace_of(io_dev_e d, int unsigned type_wt,
                                          int unsigned punch_wt, int unsigned read_wt);
    case (d)
      DEV_PUNCH: return punch_wt;
      DEV_READ:  return read_wt;
      default:   return type_wt;
    endcase
  endfunction

endpackage

// File: rtl/io_dev_sched_if.sv
// io_dev_sched_if: control inputs from io_5_6, datapath char handshakes and
// host byte channel of the scheduler.
//   slave  : scheduler side
//   master : environment side (io_5_6, datapath, host bridge)
interface io_dev_sched_if;
  logic       T0, READY, SLOW_IN, SLOW_OUT, FAST, TYPE, PHOTO_TAPE_FWD;
  logic [5:0] out_char;
  logic       out_strobe;
  logic [5:0] in_char;
  logic       in_valid, in_ack;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [1:0] dev;
  logic       busy, overrun, fast_unsup;

  modport slave (
    input  T0, READY, SLOW_IN, SLOW_OUT, FAST, TYPE, PHOTO_TAPE_FWD,
           out_char, out_strobe, in_ack, tx_ready, rx_data, rx_valid,
    output in_char, in_valid, tx_data, tx_valid, rx_ready, dev, busy, overrun, fast_unsup
  );

  modport master (
    output T0, READY, SLOW_IN, SLOW_OUT, FAST, TYPE, PHOTO_TAPE_FWD,
           out_char, out_strobe, in_ack, tx_ready, rx_data, rx_valid,
    input  in_char, in_valid, tx_data, tx_valid, rx_ready, dev, busy, overrun, fast_unsup
  );
endinterface

// File: rtl/io_dev_sched_pace_ctr.sv
// io_pace_ctr: word-time pace counter.
//   i_clk/i_rst  clock, synchronous active-high reset
//   i_clr        force to 0
//   i_load       load i_load_val (beats a coincident i_t0)
//   i_t0         word-time pulse; decrements, saturating at 0
//   o_zero       count is 0
module io_pace_ctr #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_t0,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)                     r_cnt <= '0;
    else if (i_clr)                r_cnt <= '0;
    else if (i_load)               r_cnt <= i_load_val;
    else if (i_t0 && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/io_dev_sched.sv
// io_dev_sched: paces G-15 slow-device characters between the datapath and a
// host byte channel, one device at a time, at that device's word-time rate.
//   i_clk, i_rst   clock, synchronous active-high reset
//   bus (slave)    io_5_6 decode inputs, T0, datapath out/in handshakes,
//                  host tx/rx byte channel, dev/busy/overrun/fast_unsup status
module io_dev_sched
  import io_dev_sched_pkg::*;
#(
  parameter int unsigned TYPE_PACE_WT  = DEF_TYPE_PACE_WT,
  parameter int unsigned PUNCH_PACE_WT = DEF_PUNCH_PACE_WT,
  parameter int unsigned READ_PACE_WT  = DEF_READ_PACE_WT,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic           i_clk,
  input  logic           i_rst,
  io_dev_sched_if.slave  bus
);
  io_sched_state_e  r_state, w_next;
  io_dev_e          r_dev, w_dec_dev;
  logic [5:0]       r_buf, r_in_char;
  logic             r_buf_full, r_abort_pend, r_overrun, r_fast_unsup;
  logic             w_abort, w_tx_hs, w_rx_take, w_in_done, w_strobe_win, w_fill;
  logic             w_zero, w_tx_valid, w_in_valid;
  logic [CNT_W-1:0] w_load_val;

  assign w_dec_dev = bus.SLOW_OUT ? (bus.TYPE ? DEV_TYPE : DEV_PUNCH)
                                  : (bus.PHOTO_TAPE_FWD ? DEV_READ : DEV_KEYB);
  assign w_abort   = bus.READY | (w_dec_dev != r_dev);
  assign w_tx_hs   = (r_state == OUT_XFER) & bus.tx_ready;
  assign w_rx_take = (r_state == IN_WAIT) & bus.rx_valid & (bus.rx_data[7:6] == 2'(r_dev));
  assign w_in_done = (r_state == IN_DELIVER) & bus.in_ack;
  // The out buffer can take a char while an out device is waiting, pacing,
  // or sending; in OUT_XFER it is always full, so a strobe there overruns.
  assign w_strobe_win = ~r_dev[1] & (r_state inside {OUT_WAIT, OUT_XFER, PACE});
  assign w_fill       = bus.out_strobe & w_strobe_win & ~r_buf_full;
  assign w_load_val   = CNT_W'(pace_of(r_dev, TYPE_PACE_WT, PUNCH_PACE_WT, READ_PACE_WT));

  io_pace_ctr #(.CNT_W(CNT_W)) u_pace (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(r_state == ARM), .i_load(w_tx_hs | w_in_done),
    .i_load_val(w_load_val), .i_t0(bus.T0), .o_zero(w_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:       if (~bus.READY & (bus.SLOW_IN | bus.SLOW_OUT) & ~bus.FAST) w_next = ARM;
      // r_dev is not latched yet, so only READY can abort here.
      ARM:        w_next = bus.READY ? IDLE : (w_dec_dev[1] ? IN_WAIT : OUT_WAIT);
      OUT_WAIT:   if (w_abort) w_next = IDLE;
                  else if (r_buf_full | bus.out_strobe) w_next = OUT_XFER;
      // A started host transfer is never torn down; an abort seen meanwhile
      // is remembered and taken at the handshake.
      OUT_XFER:   if (bus.tx_ready) w_next = (r_abort_pend | w_abort) ? IDLE : PACE;
      IN_WAIT:    if (w_abort) w_next = IDLE;
                  else if (w_rx_take) w_next = IN_DELIVER;
      IN_DELIVER: if (w_abort) w_next = IDLE;
                  else if (bus.in_ack) w_next = PACE;
      PACE:       if (w_abort) w_next = IDLE;
                  else if (w_zero) w_next = r_dev[1] ? IN_WAIT : (r_buf_full ? OUT_XFER : OUT_WAIT);
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dev        <= DEV_TYPE;
      r_buf        <= '0;
      r_buf_full   <= 1'b0;
      r_in_char    <= '0;
      r_abort_pend <= 1'b0;
      r_overrun    <= 1'b0;
      r_fast_unsup <= 1'b0;
    end else begin
      r_fast_unsup <= bus.FAST & ~bus.READY;
      if (r_state == ARM) r_dev <= w_dec_dev;
      if (w_next == IDLE || w_tx_hs) r_buf_full <= 1'b0;
      else if (w_fill) begin
        r_buf_full <= 1'b1;
        r_buf      <= bus.out_char;
      end
      if (w_rx_take) r_in_char <= bus.rx_data[5:0];
      r_abort_pend <= (r_state == OUT_XFER) & (r_abort_pend | w_abort);
      if (bus.READY) r_overrun <= 1'b0;
      else if (bus.out_strobe & w_strobe_win & r_buf_full) r_overrun <= 1'b1;
    end
  end

  assign w_tx_valid = (r_state == OUT_XFER);
  assign w_in_valid = (r_state == IN_DELIVER);

  always_comb begin
    bus.tx_valid   = w_tx_valid;
    bus.tx_data    = w_tx_valid ? {2'(r_dev), r_buf} : 8'h00;
    bus.rx_ready   = (r_state == IN_WAIT);
    bus.in_valid   = w_in_valid;
    bus.in_char    = w_in_valid ? r_in_char : 6'h00;
    bus.dev        = 2'(r_dev);
    bus.busy       = (r_state != IDLE);
    bus.overrun    = r_overrun;
    bus.fast_unsup = r_fast_unsup;
  end
endmodule
